// File: rtl/hdmi_pkg.sv
// Shared TMDS receive definitions: control tokens, TERC4 code table,
// alignment FSM states and word-level decode helpers.
// TERC4 lookup is only used when HDMI_RX_TERC4_EN is defined.
package hdmi_pkg;

    // Control tokens, named by {C1,C0}
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    // TERC4 code words indexed by nibble value
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } tmds_align_state_t;

    function automatic logic tmds_is_token(input logic [9:0] w);
        logic hit;
        case (w)
            CTRL_TOKEN_00, CTRL_TOKEN_01,
            CTRL_TOKEN_10, CTRL_TOKEN_11: hit = 1'b1;
            default:                      hit = 1'b0;
        endcase
        return hit;
    endfunction

    // {C1,C0} carried by a control token; 0 for any other word
    function automatic logic [1:0] tmds_ctrl_code(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            CTRL_TOKEN_01: c = 2'b01;
            CTRL_TOKEN_10: c = 2'b10;
            CTRL_TOKEN_11: c = 2'b11;
            default:       c = 2'b00;
        endcase
        return c;
    endfunction

    // Undo the XOR/XNOR transition chain and optional inversion
    function automatic logic [7:0] tmds_decode8(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    // {hit, nibble}; nibble is 0 when the word is not a TERC4 code
    function automatic logic [4:0] tmds_terc4_lookup(input logic [9:0] w);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (w == TERC4_TABLE[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_tmds_rx_aligner.sv
// Per-channel word aligner: watches the raw word stream for control tokens,
// requests single-bit slips while unaligned and reports lock.
module tmds_channel_aligner
    import hdmi_pkg::*;
#(
    parameter int LOCK_TOKENS  = 16,
    parameter int SEARCH_WORDS = 2048,
    parameter int SLIP_WAIT    = 8,
    parameter int MAX_GAP      = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] word_i,
    input  logic       valid_i,
    output logic       token_o,
    output logic       bitslip_o,
    output logic       locked_o
);

    localparam int GAP_TOP = (SEARCH_WORDS > MAX_GAP) ? SEARCH_WORDS : MAX_GAP;
    localparam int TOK_W   = $clog2(LOCK_TOKENS + 1);
    localparam int GAP_W   = $clog2(GAP_TOP + 1);
    localparam int SLIP_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [TOK_W-1:0]  TOK_FULL  = TOK_W'(LOCK_TOKENS);
    localparam logic [GAP_W-1:0]  SRCH_LAST = GAP_W'(SEARCH_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MAX_GAP - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

    tmds_align_state_t state_q, state_d;
    logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
    logic              bitslip_q, bitslip_d;
    logic              tok_q;
    logic              vld_q;

    // Register token flag and valid so the FSM sees the same word as the decode stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tok_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            tok_q <= tmds_is_token(word_i);
            vld_q <= valid_i;
        end
    end

    // FSM state, counters and slip pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            tok_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tok_cnt_q  <= tok_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
        end
    end

    // Next-state logic; counters stop at their thresholds because the state leaves there
    always_comb begin
        state_d    = state_q;
        tok_cnt_d  = tok_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        slip_cnt_d = slip_cnt_q;
        bitslip_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vld_q) begin
                    if (tok_q) begin
                        // a token always beats a pending gap threshold
                        gap_cnt_d = '0;
                        if (tok_cnt_q == TOK_LAST) begin
                            tok_cnt_d = TOK_FULL;
                            state_d   = LOCKED;
                        end else begin
                            tok_cnt_d = tok_cnt_q + 1'b1;
                        end
                    end else begin
                        tok_cnt_d = '0;
                        if (gap_cnt_q == SRCH_LAST) begin
                            gap_cnt_d  = '0;
                            slip_cnt_d = '0;
                            bitslip_d  = 1'b1;
                            state_d    = SLIP;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                end
            end
            SLIP: begin
                // words arriving while the deserialiser settles are ignored
                if (slip_cnt_q == SLIP_LAST) begin
                    slip_cnt_d = '0;
                    tok_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    state_d    = SEARCH;
                end else begin
                    slip_cnt_d = slip_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (vld_q) begin
                    if (tok_q) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        // lost tokens: re-search at the current phase, no slip
                        gap_cnt_d = '0;
                        tok_cnt_d = '0;
                        state_d   = SEARCH;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign token_o   = tok_q;
    assign bitslip_o = bitslip_q;
    assign locked_o  = (state_q == LOCKED);

endmodule

// File: rtl/hdmi_tmds_rx.sv
// TMDS receive decoder top: per-channel aligners, two-stage decode pipeline,
// DE/sync generation. Optional TERC4 lookup enabled by HDMI_RX_TERC4_EN.
module hdmi_tmds_rx
    import hdmi_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int LOCK_TOKENS  = 16,
    parameter int SEARCH_WORDS = 2048,
    parameter int SLIP_WAIT    = 8,
    parameter int MAX_GAP      = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*10-1:0] tmds_word,
    input  logic                 word_valid,
    output logic [NUM_CH-1:0]    bitslip,
    output logic [NUM_CH-1:0]    ch_locked,
    output logic                 all_locked,
    output logic [NUM_CH*8-1:0]  pix_data,
    output logic [NUM_CH*2-1:0]  ctrl,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 out_valid,
    output logic [NUM_CH*4-1:0]  terc4,
    output logic [NUM_CH-1:0]    terc4_hit
);

    logic [NUM_CH-1:0]    tok_p0;
    logic [NUM_CH*10-1:0] word_p0;
    logic                 vld_p0;
    logic [NUM_CH*8-1:0]  dec_p0;
    logic [NUM_CH*2-1:0]  code_p0;
    logic                 de_p0;

    logic                 vld_p1;
    logic                 de_p1;
    logic [NUM_CH*8-1:0]  pix_p1;
    logic [NUM_CH*2-1:0]  ctrl_p1;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        tmds_channel_aligner #(
            .LOCK_TOKENS  (LOCK_TOKENS),
            .SEARCH_WORDS (SEARCH_WORDS),
            .SLIP_WAIT    (SLIP_WAIT),
            .MAX_GAP      (MAX_GAP)
        ) u_align (
            .clk_i     (clk),
            .rst_i     (rst),
            .word_i    (tmds_word[10*n +: 10]),
            .valid_i   (word_valid),
            .token_o   (tok_p0[n]),
            .bitslip_o (bitslip[n]),
            .locked_o  (ch_locked[n])
        );
    end

    assign all_locked = &ch_locked;

    // ---- stage p0: capture input words ----
    // Valid strobe for stage p0
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= word_valid;
    end

    // Input word register; holds while word_valid is low
    always_ff @(posedge clk) begin
        if (word_valid) word_p0 <= tmds_word;
    end

    // Per-channel data decode and control code extraction
    always_comb begin
        dec_p0  = '0;
        code_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dec_p0[8*i +: 8]  = tmds_decode8(word_p0[10*i +: 10]);
            code_p0[2*i +: 2] = tmds_ctrl_code(word_p0[10*i +: 10]);
        end
    end

    assign de_p0 = all_locked & ~(|tok_p0);

    // ---- stage p1: output registers ----
    // ctrl updates only on tokens, pixel data only in the video period
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            de_p1   <= 1'b0;
            ctrl_p1 <= '0;
            pix_p1  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                de_p1 <= de_p0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (tok_p0[i]) ctrl_p1[2*i +: 2] <= code_p0[2*i +: 2];
                end
                if (de_p0) pix_p1 <= dec_p0;
            end
        end
    end

`ifdef HDMI_RX_TERC4_EN
    logic [NUM_CH*4-1:0] t4_p0;
    logic [NUM_CH-1:0]   t4_hit_p0;
    logic [NUM_CH*4-1:0] t4_p1;
    logic [NUM_CH-1:0]   t4_hit_p1;

    // TERC4 table match for each channel word
    always_comb begin
        t4_p0     = '0;
        t4_hit_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            {t4_hit_p0[i], t4_p0[4*i +: 4]} = tmds_terc4_lookup(word_p0[10*i +: 10]);
        end
    end

    // TERC4 result registered alongside pixel data
    always_ff @(posedge clk) begin
        if (rst) begin
            t4_p1     <= '0;
            t4_hit_p1 <= '0;
        end else if (vld_p0) begin
            t4_p1     <= t4_p0;
            t4_hit_p1 <= t4_hit_p0;
        end
    end

    assign terc4     = t4_p1;
    assign terc4_hit = t4_hit_p1;
`else
    assign terc4     = '0;
    assign terc4_hit = '0;
`endif

    assign pix_data  = pix_p1;
    assign ctrl      = ctrl_p1;
    assign de        = de_p1;
    assign hsync     = ctrl_p1[0];
    assign vsync     = ctrl_p1[1];
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_hdmi_tmds_rx.sv
// Testbench for hdmi_tmds_rx: directed lock/slip/gap/reset steps plus a
// randomized decode phase checked against a word-level reference model.
module tb_hdmi_tmds_rx;

    localparam int NCH = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH*10-1:0] tmds_word;
    logic            word_valid;
    logic [NCH-1:0]  bitslip;
    logic [NCH-1:0]  ch_locked;
    logic            all_locked;
    logic [NCH*8-1:0] pix_data;
    logic [NCH*2-1:0] ctrl;
    logic            de;
    logic            hsync;
    logic            vsync;
    logic            out_valid;
    logic [NCH*4-1:0] terc4;
    logic [NCH-1:0]  terc4_hit;

    always #5 clk = ~clk;

    hdmi_tmds_rx #(
        .NUM_CH(NCH), .LOCK_TOKENS(16), .SEARCH_WORDS(2048),
        .SLIP_WAIT(8), .MAX_GAP(4096)
    ) dut (
        .clk(clk), .rst(rst), .tmds_word(tmds_word), .word_valid(word_valid),
        .bitslip(bitslip), .ch_locked(ch_locked), .all_locked(all_locked),
        .pix_data(pix_data), .ctrl(ctrl), .de(de), .hsync(hsync), .vsync(vsync),
        .out_valid(out_valid), .terc4(terc4), .terc4_hit(terc4_hit)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] T4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] DATA_W0 = 10'b0110011010;

    // reference model state
    logic [7:0] m_pix [NCH];
    logic [1:0] m_ctrl [NCH];
    logic [3:0] m_t4 [NCH];
    logic       m_t4hit [NCH];
    logic       m_de, m_ov, m_all_locked, m_check;
    logic       pv;
    logic [NCH*10-1:0] pw;

    function automatic int tok_idx(logic [9:0] w);
        for (int i = 0; i < 4; i++) if (TOK[i] == w) return i;
        return -1;
    endfunction

    function automatic int t4_idx(logic [9:0] w);
        for (int i = 0; i < 16; i++) if (T4[i] == w) return i;
        return -1;
    endfunction

    // bit i of q is d[i]^d[i-1] (XNOR when w[8]=0), bit 0 is d[0]
    function automatic logic [7:0] m_decode(logic [9:0] w);
        logic [7:0] d, x;
        d = w[7:0] ^ {8{w[9]}};
        x = d ^ (d << 1);
        if (!w[8]) x = ~x ^ 8'h01;
        return x;
    endfunction

    // word seen by the receiver when the serial token stream is off by 'off' bits
    function automatic logic [9:0] rotw(int off);
        logic [9:0] t, r;
        t = TOK[0];
        for (int k = 0; k < 10; k++) r[k] = t[(off + k) % 10];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_pix[c] = '0; m_ctrl[c] = '0; m_t4[c] = '0; m_t4hit[c] = 1'b0;
        end
        m_de = 1'b0; m_ov = 1'b0; pv = 1'b0; pw = '0; m_all_locked = 1'b0;
    endtask

    task automatic model_word(input logic [NCH*10-1:0] w);
        logic anytok;
        int   ti;
        anytok = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ti = tok_idx(w[10*c +: 10]);
            if (ti >= 0) begin
                anytok = 1'b1;
                m_ctrl[c] = 2'(ti);
            end
        end
        m_de = m_all_locked && !anytok;
        for (int c = 0; c < NCH; c++) begin
            if (m_de) m_pix[c] = m_decode(w[10*c +: 10]);
`ifdef HDMI_RX_TERC4_EN
            ti = t4_idx(w[10*c +: 10]);
            m_t4hit[c] = (ti >= 0);
            m_t4[c]    = (ti >= 0) ? 4'(ti) : 4'h0;
`endif
        end
    endtask

    task automatic check_outputs();
        logic [NCH*8-1:0] ep;
        logic [NCH*2-1:0] ec;
        logic [NCH*4-1:0] et;
        logic [NCH-1:0]   eh;
        for (int c = 0; c < NCH; c++) begin
            ep[8*c +: 8] = m_pix[c];
            ec[2*c +: 2] = m_ctrl[c];
            et[4*c +: 4] = m_t4[c];
            eh[c]        = m_t4hit[c];
        end
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("pix_data", 64'(pix_data), 64'(ep));
        chk("ctrl", 64'(ctrl), 64'(ec));
        chk("de", 64'(de), 64'(m_de));
        chk("hsync_vsync", 64'({vsync, hsync}), 64'(m_ctrl[0]));
        chk("terc4", 64'({terc4_hit, terc4}), 64'({eh, et}));
    endtask

    // one clock: drive inputs, clock, then compare against the word issued one step earlier
    task automatic step(input logic v, input logic [NCH*10-1:0] w);
        word_valid = v;
        tmds_word  = w;
        @(posedge clk);
        #1;
        m_ov = pv;
        if (pv) model_word(pw);
        if (m_check) check_outputs();
        pv = v;
        pw = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        word_valid = 1'b0;
        tmds_word = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("reset_ctl", 64'({bitslip, ch_locked, all_locked, ctrl, de, hsync, vsync, out_valid, terc4_hit}), 64'(0));
        chk("reset_data", 64'({pix_data, terc4}), 64'(0));
        rst = 1'b0;
    endtask

    initial begin
        logic [NCH*10-1:0] w;
        logic [9:0]        wc;
        int                r, slips, other, cyc, off;
        logic              got;
        int                stamp[$];

        rst = 1'b1; word_valid = 1'b0; tmds_word = '0; m_check = 1'b0;
        model_clear();
        do_reset();
        m_check = 1'b1;

        // lock on 16 tokens
        for (int i = 0; i < 16; i++) step(1'b1, {NCH{TOK[0]}});
        chk("lock_not_early", 64'(ch_locked), 64'(0));
        step(1'b0, '0);
        chk("lock_at_17", 64'(ch_locked), 64'(3'b111));
        chk("all_locked", 64'(all_locked), 64'(1));
        chk("lock_ctrl", 64'(ctrl), 64'(0));
        chk("lock_de", 64'(de), 64'(0));
        m_all_locked = 1'b1;

        // data word decode
        step(1'b1, {NCH{DATA_W0}});
        step(1'b0, '0);
        chk("data_pix", 64'(pix_data), 64'({NCH{m_decode(DATA_W0)}}));
        chk("data_de", 64'(de), 64'(1));

        // hsync/vsync token on channel 0, held through data
        step(1'b1, {DATA_W0, DATA_W0, TOK[3]});
        step(1'b1, {NCH{DATA_W0}});
        chk("sync_tok", 64'({hsync, vsync, de}), 64'(3'b110));
        step(1'b1, {NCH{DATA_W0}});
        chk("sync_hold", 64'({hsync, vsync, de}), 64'(3'b111));
        step(1'b0, '0);
        chk("sync_hold_idle", 64'({hsync, vsync}), 64'(2'b11));

        // randomized mix of data, tokens and TERC4 codes with valid gaps
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                r = $urandom_range(0, 9);
                if (r < 2) wc = TOK[$urandom_range(0, 3)];
                else if (r < 3) wc = T4[$urandom_range(0, 15)];
                else begin
                    do wc = 10'($urandom); while (tok_idx(wc) >= 0);
                end
                w[10*c +: 10] = wc;
            end
            step(($urandom_range(0, 3) != 0), w);
        end

        // TERC4 code 0
        step(1'b1, {NCH{T4[0]}});
        step(1'b0, '0);
`ifdef HDMI_RX_TERC4_EN
        chk("terc4_code0", 64'({terc4_hit, terc4}), 64'({3'b111, 12'h000}));
`else
        chk("terc4_off", 64'({terc4_hit, terc4}), 64'(0));
`endif

        // gap while locked: unlock after MAX_GAP words, no slip
        m_check = 1'b0;
        slips = 0;
        step(1'b1, {NCH{TOK[0]}});
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, {NCH{DATA_W0}});
            if (|bitslip) slips++;
        end
        chk("gap_still_locked", 64'(ch_locked), 64'(3'b111));
        step(1'b0, '0);
        chk("gap_unlocked", 64'(ch_locked), 64'(0));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, {NCH{DATA_W0}});
            if (|bitslip) slips++;
        end
        chk("gap_no_slip", 64'(slips), 64'(0));

        // channel 1 three bits out of phase: expect three slips then lock
        do_reset();
        off = 7; cyc = 0; other = 0;
        while (cyc < 12000 && ch_locked !== 3'b111) begin
            step(1'b1, {TOK[0], rotw(off), TOK[0]});
            cyc++;
            if (bitslip[1]) begin
                stamp.push_back(cyc);
                off = (off + 1) % 10;
            end
            if (bitslip[0] | bitslip[2]) other++;
        end
        chk("slip_count", 64'(stamp.size()), 64'(3));
        chk("slip_other_ch", 64'(other), 64'(0));
        chk("slip_locked", 64'(ch_locked), 64'(3'b111));
        if (stamp.size() > 0) chk("slip_first_late", 64'(stamp[0] >= 2048), 64'(1));
        for (int i = 1; i < stamp.size(); i++)
            chk("slip_spacing", 64'((stamp[i] - stamp[i-1]) >= 2056), 64'(1));

        // reset while channel 1 is waiting after a slip
        do_reset();
        off = 7; cyc = 0; got = 1'b0;
        while (cyc < 3000 && !got) begin
            step(1'b1, {TOK[0], rotw(off), TOK[0]});
            cyc++;
            if (bitslip[1]) got = 1'b1;
        end
        chk("midslip_seen", 64'(got), 64'(1));
        step(1'b1, {TOK[0], rotw(off + 1), TOK[0]});
        step(1'b1, {TOK[0], rotw(off + 1), TOK[0]});
        chk("midslip_pre", 64'(ch_locked), 64'(3'b101));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midslip_reset_ctl", 64'({bitslip, ch_locked, all_locked, ctrl, de, hsync, vsync, out_valid, terc4_hit}), 64'(0));
        chk("midslip_reset_data", 64'({pix_data, terc4}), 64'(0));
        rst = 1'b0;
        word_valid = 1'b0;
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
